multicycle_control: RTL and testbench

//  Control FSM that drives the datapath control inputs (PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC).

---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath:
// instruction fetch / data memory handshakes in, datapath control strobes out.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        iReady;
  logic        Zero;
  logic        dReady;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  ImmSel;
  logic        illegal;
  logic        mem_err;
  logic [2:0]  state;

  // Datapath / memory side.
  modport master (
    output instr, iReady, Zero, dReady,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
           MemRead, MemWrite, ImmSel, illegal, mem_err, state
  );

  // Controller side.
  modport slave (
    input  instr, iReady, Zero, dReady,
    output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
           MemRead, MemWrite, ImmSel, illegal, mem_err, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM (IF/ID/EX/MEM/WB, one state per cycle).
// Decodes R-type, I-type ALU, LW, SW, BEQ and BNE; flags illegal encodings
// and data-memory timeouts. Outputs are Moore, decoded from the state and
// the captured instruction / zero flag.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // Last MEM cycle index before the access is declared timed out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic       legal;
    logic [3:0] alu;
    logic       alu_src;
    logic [1:0] imm_sel;
    logic       writes_reg;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
  } dec_t;

  // ALU operation for the shared R/I-type funct3 table; alt selects SUB/SRA.
  function automatic logic [3:0] alu_for(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Full decode of the captured {funct7, funct3, opcode} fields. An illegal
  // encoding returns the idle decode (ADD, no side effects) with legal=0.
  function automatic dec_t decode(input logic [16:0] f);
    dec_t       d;
    dec_t       idle;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [6:0] op;
    f7   = f[16:10];
    f3   = f[9:7];
    op   = f[6:0];
    idle = '0;
    idle.alu = ALU_ADD;
    d    = idle;
    case (op)
      OP_R: begin
        d.legal      = ((f7 == 7'h00) || (f7 == 7'h20)) && (f3 != 3'b011);
        d.alu        = alu_for(f3, f7[5]);
        d.writes_reg = 1'b1;
      end
      OP_I: begin
        d.legal      = (f3 != 3'b011);
        d.alu        = alu_for(f3, (f3 == 3'b101) ? f7[5] : 1'b0);
        d.alu_src    = 1'b1;
        d.writes_reg = 1'b1;
      end
      OP_LW: begin
        d.legal      = (f3 == 3'b010);
        d.alu_src    = 1'b1;
        d.writes_reg = 1'b1;
        d.is_lw      = 1'b1;
      end
      OP_SW: begin
        d.legal      = (f3 == 3'b010);
        d.alu_src    = 1'b1;
        d.imm_sel    = 2'b01;
        d.is_sw      = 1'b1;
      end
      OP_BR: begin
        d.legal      = (f3 == 3'b000) || (f3 == 3'b001);
        d.alu        = ALU_SUB;
        d.imm_sel    = 2'b10;
        d.is_beq     = (f3 == 3'b000);
        d.is_bne     = (f3 == 3'b001);
      end
      default: d.legal = 1'b0;
    endcase
    return d.legal ? d : idle;
  endfunction

  state_t      state_q, state_d;
  // Only the opcode and funct fields are needed for control.
  logic [16:0] instr_q;
  logic        zero_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  dec_t        dec;

  logic        pc_src, alu_src, reg_write, mem_to_reg, load_pc;
  logic        mem_read, mem_write, illegal, mem_err;
  logic [3:0]  alu_ctrl;
  logic [1:0]  imm_sel;

  assign dec = decode(instr_q);

  // State, captured instruction/zero flag, MEM timeout counter and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      instr_q <= 17'd0;
      zero_q  <= 1'b0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == S_IF && bus.iReady) begin
        instr_q <= {bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};
      end
      if (state_q == S_EX) begin
        zero_q <= bus.Zero;
      end
    end
  end

  // Next-state sequencing, including the MEM wait and timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IF: begin
        cnt_d = 8'd0;
        err_d = 1'b0;
        if (bus.iReady) state_d = S_ID;
        else            state_d = S_IF;
      end
      S_ID:  state_d = dec.legal ? S_EX : S_WB;
      S_EX:  state_d = (dec.is_lw || dec.is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dReady) begin
          // A completion on the timeout cycle still counts as success.
          state_d = S_WB;
          cnt_d   = 8'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_WB;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Moore output decode; ALU controls stay fixed from EX through WB.
  always_comb begin
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    load_pc    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    alu_ctrl   = ALU_ADD;
    imm_sel    = 2'b00;
    case (state_q)
      S_IF, S_ID: begin
        alu_ctrl = ALU_ADD;
      end
      S_EX: begin
        alu_ctrl = dec.alu;
        alu_src  = dec.alu_src;
        imm_sel  = dec.imm_sel;
      end
      S_MEM: begin
        alu_ctrl   = dec.alu;
        alu_src    = dec.alu_src;
        imm_sel    = dec.imm_sel;
        mem_read   = dec.is_lw;
        mem_to_reg = dec.is_lw;
        mem_write  = dec.is_sw;
      end
      S_WB: begin
        alu_ctrl   = dec.alu;
        alu_src    = dec.alu_src;
        imm_sel    = dec.imm_sel;
        load_pc    = 1'b1;
        reg_write  = dec.legal && dec.writes_reg && !err_q;
        mem_to_reg = dec.is_lw;
        pc_src     = (dec.is_beq && zero_q) || (dec.is_bne && !zero_q);
        illegal    = !dec.legal;
        mem_err    = err_q;
      end
      default: begin
        alu_ctrl = ALU_ADD;
      end
    endcase
  end

  assign bus.PCSrc    = pc_src;
  assign bus.ALUSrc   = alu_src;
  assign bus.RegWrite = reg_write;
  assign bus.MemToReg = mem_to_reg;
  assign bus.ALUCtrl  = alu_ctrl;
  assign bus.loadPC   = load_pc;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.ImmSel   = imm_sel;
  assign bus.illegal  = illegal;
  assign bus.mem_err  = mem_err;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Observed outputs are packed as
// {state[3], ALUCtrl[4], ImmSel[2],
//  PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal, mem_err}
// and compared against hand-computed words.
module tb_multicycle_control;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_control_if bus();

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] obs();
    return {bus.state, bus.ALUCtrl, bus.ImmSel,
            bus.PCSrc, bus.ALUSrc, bus.RegWrite, bus.MemToReg, bus.loadPC,
            bus.MemRead, bus.MemWrite, bus.illegal, bus.mem_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in IF for a single cycle; afterwards state is ID.
  task automatic fetch(input logic [31:0] w);
    bus.instr  = w;
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
    bus.instr  = 32'hDEADBEEF;
  endtask

  // Branch with a given Zero during EX (Zero held opposite elsewhere).
  task automatic branch(input string tag, input logic [31:0] w, input logic z,
                        input logic [17:0] exp_wb);
    bus.Zero = ~z;
    fetch(w);
    tick();
    check({tag, "_ex"}, obs(), {3'd2, 4'b0110, 2'b10, 9'b000000000});
    bus.Zero = z;
    tick();
    bus.Zero = ~z;
    check({tag, "_wb"}, obs(), exp_wb);
    tick();
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.instr  = 32'd0;
    bus.iReady = 1'b0;
    bus.Zero   = 1'b0;
    bus.dReady = 1'b0;
    repeat (2) tick();
    check("reset", obs(), {3'd0, 4'b0010, 2'b00, 9'b000000000});
    rst = 1'b0;
    tick();
    check("if_hold", obs(), {3'd0, 4'b0010, 2'b00, 9'b000000000});

    // add x3,x1,x2
    fetch(32'h002081B3);
    check("add_id", obs(), {3'd1, 4'b0010, 2'b00, 9'b000000000});
    tick();
    check("add_ex", obs(), {3'd2, 4'b0010, 2'b00, 9'b000000000});
    tick();
    check("add_wb", obs(), {3'd4, 4'b0010, 2'b00, 9'b001010000});
    tick();
    check("add_if", obs(), {3'd0, 4'b0010, 2'b00, 9'b000000000});

    // sub: ADD shown in ID, SUB from EX onward
    fetch(32'h402081B3);
    check("sub_id", obs(), {3'd1, 4'b0010, 2'b00, 9'b000000000});
    tick();
    check("sub_ex", obs(), {3'd2, 4'b0110, 2'b00, 9'b000000000});
    tick();
    check("sub_wb", obs(), {3'd4, 4'b0110, 2'b00, 9'b001010000});
    tick();

    // xori (I-type)
    fetch(32'h0000C093);
    tick();
    check("xori_ex", obs(), {3'd2, 4'b1101, 2'b00, 9'b010000000});
    tick();
    check("xori_wb", obs(), {3'd4, 4'b1101, 2'b00, 9'b011010000});
    tick();

    // lw with dReady low for 3 MEM cycles
    fetch(32'h0080A283);
    tick();
    check("lw_ex", obs(), {3'd2, 4'b0010, 2'b00, 9'b010000000});
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_wait", obs(), {3'd3, 4'b0010, 2'b00, 9'b010101000});
      tick();
    end
    check("lw_mem_last", obs(), {3'd3, 4'b0010, 2'b00, 9'b010101000});
    bus.dReady = 1'b1;
    tick();
    bus.dReady = 1'b0;
    check("lw_wb", obs(), {3'd4, 4'b0010, 2'b00, 9'b011110000});
    tick();

    // sw with immediate dReady
    fetch(32'h0020A223);
    tick();
    check("sw_ex", obs(), {3'd2, 4'b0010, 2'b01, 9'b010000000});
    tick();
    check("sw_mem", obs(), {3'd3, 4'b0010, 2'b01, 9'b010000100});
    bus.dReady = 1'b1;
    tick();
    bus.dReady = 1'b0;
    check("sw_wb", obs(), {3'd4, 4'b0010, 2'b01, 9'b010010000});
    tick();

    // sw with dReady stuck low: MEM for 16 cycles then WB with mem_err
    fetch(32'h0020A223);
    tick();
    tick();
    n = 0;
    while (bus.state == 3'd3 && n < 40) begin
      n++;
      tick();
    end
    check("sw_timeout_cycles", n, 16);
    check("sw_timeout_wb", obs(), {3'd4, 4'b0010, 2'b01, 9'b010010001});
    tick();
    check("sw_timeout_if", obs(), {3'd0, 4'b0010, 2'b00, 9'b000000000});

    // error does not leak into the next instruction
    fetch(32'h002081B3);
    tick();
    tick();
    check("add_after_err_wb", obs(), {3'd4, 4'b0010, 2'b00, 9'b001010000});
    tick();

    // branches
    branch("beq_z1", 32'h00208463, 1'b1, {3'd4, 4'b0110, 2'b10, 9'b100010000});
    branch("beq_z0", 32'h00208463, 1'b0, {3'd4, 4'b0110, 2'b10, 9'b000010000});
    branch("bne_z1", 32'h00209463, 1'b1, {3'd4, 4'b0110, 2'b10, 9'b000010000});
    branch("bne_z0", 32'h00209463, 1'b0, {3'd4, 4'b0110, 2'b10, 9'b100010000});
    bus.Zero = 1'b0;

    // illegal opcode: IF, ID, WB
    fetch(32'hFFFFFFFF);
    check("ill_id", obs(), {3'd1, 4'b0010, 2'b00, 9'b000000000});
    tick();
    check("ill_wb", obs(), {3'd4, 4'b0010, 2'b00, 9'b000010010});
    tick();
    check("ill_if", obs(), {3'd0, 4'b0010, 2'b00, 9'b000000000});

    // R-type with funct7=0x01 is illegal
    fetch(32'h022081B3);
    tick();
    check("ill_f7_wb", obs(), {3'd4, 4'b0010, 2'b00, 9'b000010010});
    tick();

    // R-type funct3=011 is illegal
    fetch(32'h0020B1B3);
    tick();
    check("ill_f3_wb", obs(), {3'd4, 4'b0010, 2'b00, 9'b000010010});
    tick();

    // reset while sw is waiting in MEM
    fetch(32'h0020A223);
    tick();
    tick();
    check("rst_pre_mem", obs(), {3'd3, 4'b0010, 2'b01, 9'b010000100});
    rst = 1'b1;
    tick();
    check("rst_in_mem", obs(), {3'd0, 4'b0010, 2'b00, 9'b000000000});
    rst = 1'b0;
    tick();
    check("rst_after", obs(), {3'd0, 4'b0010, 2'b00, 9'b000000000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
